booth2_mul_pipe_adder: RTL and testbench
========================================

BOOTH2_MUL_PIPE_ADDER -- requirements
Module: booth2_mul_pipe_adder

Interface
REQ-001 The block SHALL have parameter DATA_THR, default 32: operand/result width in bits.
REQ-002 The block SHALL have parameter SEG_WD, default 4: width of one carry-lookahead segment.
REQ-003 The block SHALL have parameter PIPE_STG, default 2: number of register stages, which is also the no-stall latency.
REQ-004 Legal parameters SHALL satisfy DATA_THR % SEG_WD == 0, PIPE_STG >= 1 and (DATA_THR/SEG_WD) % PIPE_STG == 0; any other combination SHALL stop elaboration with an error.
REQ-005 Port clk  input  1: single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rstn  input  1: asynchronous, active-low reset.
REQ-007 Port val_i  input  1: input transaction valid.
REQ-008 Port rdy_o  output  1: block can accept an input this cycle.
REQ-009 Port ai  input  DATA_THR: operand A.
REQ-010 Port bi  input  DATA_THR: operand B.
REQ-011 Port cin  input  1: carry-in, used in add mode only.
REQ-012 Port sub_i  input  1: 0 = add, 1 = subtract.
REQ-013 Port val_o  output  1: result valid.
REQ-014 Port rdy_i  input  1: downstream accepts the result.
REQ-015 Port so  output  DATA_THR: sum or difference.
REQ-016 Port cout  output  1: carry out of the MSB.
REQ-017 Port ovf  output  1: two's-complement signed overflow.

Function
REQ-018 Arithmetic SHALL be: add gives {cout,so} = ai + bi + cin; subtract gives {cout,so} = ai + ~bi + 1, with cin ignored.
REQ-019 ovf SHALL be 1 exactly when the effective operand MSBs (ai, and bi or ~bi) are equal and so's MSB differs from them.
REQ-020 The datapath SHALL be split into PIPE_STG groups of (DATA_THR/SEG_WD)/PIPE_STG segments each.
REQ-021 Stage k SHALL add group k (LSB group first), taking its carry-in from the carry register of stage k-1; stage 1 SHALL take the effective carry-in.
REQ-022 Within a stage, segments SHALL chain by lookahead carry, and no carry SHALL ripple combinationally across a stage register.
REQ-023 The unprocessed upper operand bits SHALL be delayed alongside each transaction, and completed lower result bits SHALL be delayed so that all of so is aligned at the output.
REQ-024 Global enable SHALL be en = !val_o | rdy_i, and rdy_o SHALL equal en.
REQ-025 A transfer SHALL occur on any cycle with val_i && rdy_o, and a result SHALL be consumed on any cycle with val_o && rdy_i.
REQ-026 When en=1, every stage valid bit SHALL advance one stage, and the stage-1 valid SHALL load val_i.
REQ-027 When en=0, all stages SHALL hold, and val_i SHALL be ignored.
REQ-028 A stage's data registers SHALL load only when en=1 and its incoming valid is 1; otherwise they SHALL hold, so bubbles leave data unchanged.
REQ-029 Latency SHALL be exactly PIPE_STG cycles from transfer to val_o when no stall occurs.
REQ-030 Throughput SHALL be one result per cycle with back-to-back inputs and rdy_i held at 1.
REQ-031 Bubbles SHALL NOT be collapsed, and results SHALL leave in input order with none lost or duplicated.
REQ-032 so, cout and ovf SHALL remain stable while val_o=1 and rdy_i=0.
REQ-033 Simultaneous consume at the output and accept at the input in the same cycle SHALL be permitted.
REQ-034 The full-width carry (for example 0xFFFF+1) SHALL propagate through every stage boundary via the carry registers, with the correct result after PIPE_STG cycles.

Reset
REQ-035 While rstn=0, all stage valids, val_o, so, cout, ovf and all internal data and carry registers SHALL be 0 immediately, without waiting for clk.
REQ-036 While rstn=0, rdy_o SHALL be 1, since it follows from val_o=0.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight transactions, and no stale result SHALL appear after release.
REQ-038 The first input accepted on the first clock edge after release SHALL be processed normally.

Verification (DATA_THR=16, SEG_WD=4, PIPE_STG=2)
REQ-039 The bench SHALL check: add 0x00FF+0x0001, cin=0 -> 2 cycles later val_o=1, so=0x0100, cout=0, ovf=0.
REQ-040 The bench SHALL check: add 0xFFFF+0x0000, cin=1 -> so=0x0000, cout=1, ovf=0, with the carry crossing the stage boundary.
REQ-041 The bench SHALL check: sub 0x0000-0x0001, with cin=1 driven and ignored -> so=0xFFFF, cout=0, ovf=0; and sub 0x8000-0x0001 -> so=0x7FFF, cout=1, ovf=1.
REQ-042 The bench SHALL check: add 0x7FFF+0x0001 -> so=0x8000, ovf=1, cout=0.
REQ-043 The bench SHALL check: inputs 1+1, 2+2 and 3+3 back-to-back, with rdy_i=0 for 3 cycles once the first is valid -> rdy_o=0, so held at 0x0002, then 0x0002, 0x0004, 0x0006 delivered in order on consecutive cycles.
REQ-044 The bench SHALL check: two transactions in flight, rstn pulsed low mid-cycle -> val_o=0 and so=0 immediately, and no output appears after release until a new input is sent.

Source files
------------

// File: rtl/booth2_mul_pipe_adder.sv
// Pipelined carry-lookahead add/subtract. The operands are cut into PIPE_STG groups
// (LSB first); each stage adds one group and passes its carry on through a register.

module booth2_mul_pipe_adder_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         g_o,
  output logic         p_o
);
  logic [W-1:0] g, p, c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Group generate/propagate depend only on the operands, never on c_i.
  always_comb begin
    g_o = 1'b0;
    for (int i = 0; i < W; i++) g_o = g[i] | (p[i] & g_o);
  end
  assign p_o = &p;

  always_comb begin
    c    = '0;
    c[0] = c_i;
    for (int i = 0; i < W-1; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign s_o = p ^ c;
endmodule

module booth2_mul_pipe_adder #(
  parameter int DATA_THR = 32,
  parameter int SEG_WD   = 4,
  parameter int PIPE_STG = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                val_i,
  output logic                rdy_o,
  input  logic [DATA_THR-1:0] ai,
  input  logic [DATA_THR-1:0] bi,
  input  logic                cin,
  input  logic                sub_i,
  output logic                val_o,
  input  logic                rdy_i,
  output logic [DATA_THR-1:0] so,
  output logic                cout,
  output logic                ovf
);
  localparam int NSEG = DATA_THR / SEG_WD;
  localparam int PSAF = (PIPE_STG < 1) ? 1 : PIPE_STG;
  localparam int SPS  = NSEG / PSAF;
  localparam int GW   = SPS * SEG_WD;

  if ((PIPE_STG < 1) || (DATA_THR % SEG_WD != 0) || (NSEG % PSAF != 0)) begin : g_bad_param
    $error("booth2_mul_pipe_adder: illegal DATA_THR/SEG_WD/PIPE_STG combination");
  end

  logic [DATA_THR-1:0] b_eff;
  logic                c_eff, en;

  // Subtract is a + ~b + 1; cin only matters in add mode.
  assign b_eff = sub_i ? ~bi : bi;
  assign c_eff = sub_i | cin;
  assign en    = ~val_o | rdy_i;
  assign rdy_o = en;

  for (genvar k = 1; k <= PIPE_STG; k++) begin : g_stg
    localparam int UW = DATA_THR - (k-1)*GW;

    logic [UW-1:0]   a_in, b_in;
    logic            c_in, v_in;
    logic [GW-1:0]   gs;
    logic [SPS-1:0]  sg, sp;
    logic [SPS:0]    cs;
    logic [k*GW-1:0] s_d, s_q;
    logic            v_q, c_q;

    // Stage k sees only the not-yet-added upper operand bits; group k-1 is its LSB slice.
    if (k == 1) begin : g_src
      assign a_in = ai;
      assign b_in = b_eff;
      assign c_in = c_eff;
      assign v_in = val_i;
      assign s_d  = gs;
    end else begin : g_src
      assign a_in = g_stg[k-1].g_up.a_q;
      assign b_in = g_stg[k-1].g_up.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_d  = {gs, g_stg[k-1].s_q};
    end

    for (genvar j = 0; j < SPS; j++) begin : g_seg
      booth2_mul_pipe_adder_seg #(.W(SEG_WD)) u_seg (
        .a_i (a_in[j*SEG_WD +: SEG_WD]),
        .b_i (b_in[j*SEG_WD +: SEG_WD]),
        .c_i (cs[j]),
        .s_o (gs[j*SEG_WD +: SEG_WD]),
        .g_o (sg[j]),
        .p_o (sp[j])
      );
    end

    always_comb begin
      cs    = '0;
      cs[0] = c_in;
      for (int j = 0; j < SPS; j++) cs[j+1] = sg[j] | (sp[j] & cs[j]);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= cs[SPS];
          s_q <= s_d;
        end
      end
    end

    if (k < PIPE_STG) begin : g_up
      logic [UW-GW-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && v_in) begin
          a_q <= a_in[UW-1:GW];
          b_q <= b_in[UW-1:GW];
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;
      assign ovf_d = (a_in[GW-1] == b_in[GW-1]) && (gs[GW-1] != a_in[GW-1]);
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           ovf_q <= 1'b0;
        else if (en && v_in) ovf_q <= ovf_d;
      end
    end
  end

  assign val_o = g_stg[PIPE_STG].v_q;
  assign so    = g_stg[PIPE_STG].s_q;
  assign cout  = g_stg[PIPE_STG].c_q;
  assign ovf   = g_stg[PIPE_STG].g_last.ovf_q;
endmodule

// File: tb/tb_booth2_mul_pipe_adder.sv
// Bench for booth2_mul_pipe_adder (16-bit, 4-bit segments, 2 stages): directed corner
// cases with literal expectations plus random traffic against an arithmetic scoreboard.
module tb_booth2_mul_pipe_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn, val_i, rdy_o, cin, sub_i, val_o, rdy_i, cout, ovf;
  logic [W-1:0] ai, bi, so;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rnd_done = 1'b0;

  always #5 clk = ~clk;

  booth2_mul_pipe_adder #(.DATA_THR(W), .SEG_WD(4), .PIPE_STG(2)) dut (
    .clk(clk), .rstn(rstn), .val_i(val_i), .rdy_o(rdy_o), .ai(ai), .bi(bi),
    .cin(cin), .sub_i(sub_i), .val_o(val_o), .rdy_i(rdy_i), .so(so),
    .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sb);
    exp_t e;
    int ua, ub, u, sa, sbv, r;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      u   = ua - ub;
      r   = sa - sbv;
      e.c = (ua >= ub);
    end else begin
      u   = ua + ub + int'(c);
      r   = sa + sbv + int'(c);
      e.c = (u > 65535);
    end
    e.s = u[15:0];
    e.v = (r > 32767) || (r < -32768);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rstn) begin
      if (val_o && rdy_i && q.size() > 0) void'(q.pop_front());
      if (val_i && rdy_o) q.push_back(model(ai, bi, cin, sub_i));
    end
  end

  always @(negedge rstn) q.delete();

  always @(negedge clk) begin
    if (rstn && val_o) begin
      if (q.size() == 0) chk("spurious_val_o", 32'(val_o), 32'(0));
      else begin
        chk("sb_so",   32'(so),   32'(q[0].s));
        chk("sb_cout", 32'(cout), 32'(q[0].c));
        chk("sb_ovf",  32'(ovf),  32'(q[0].v));
      end
    end
  end

  // Holds the transaction until it is accepted; returns 1 time unit after the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    bit acc = 1'b0;
    ai = a; bi = b; cin = c; sub_i = s; val_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = rdy_o;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("push_timeout", 32'(0), 32'(1));
    val_i = 1'b0;
  endtask

  task automatic do_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic [W-1:0] es,
                        input logic ec, input logic ev);
    push(a, b, c, s);
    @(negedge clk);
    chk({nm, "_lat1"}, 32'(val_o), 32'(0));
    @(negedge clk);
    chk({nm, "_val"},  32'(val_o), 32'(1));
    chk({nm, "_so"},   32'(so),    32'(es));
    chk({nm, "_cout"}, 32'(cout),  32'(ec));
    chk({nm, "_ovf"},  32'(ovf),   32'(ev));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; val_i = 1'b0; rdy_i = 1'b1;
    ai = '0; bi = '0; cin = 1'b0; sub_i = 1'b0;
    #2;
    chk("rst_val_o", 32'(val_o), 32'(0));
    chk("rst_so",    32'(so),    32'(0));
    chk("rst_cout",  32'(cout),  32'(0));
    chk("rst_ovf",   32'(ovf),   32'(0));
    chk("rst_rdy_o", 32'(rdy_o), 32'(1));
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    do_one("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_one("add_ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_one("sub_0_1",  16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    do_one("sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_one("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Back-pressure: stall the output for 3 cycles once the first result shows up.
    fork
      begin
        push(16'd1, 16'd1, 1'b0, 1'b0);
        push(16'd2, 16'd2, 1'b0, 1'b0);
        push(16'd3, 16'd3, 1'b0, 1'b0);
      end
      begin
        int k = 0;
        while (!val_o && k < 20) begin
          @(posedge clk);
          #1;
          k++;
        end
        chk("bp_seen", 32'(val_o), 32'(1));
        rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_rdy_o", 32'(rdy_o), 32'(0));
          chk("bp_hold",  32'(so),    32'h0002);
          chk("bp_val",   32'(val_o), 32'(1));
        end
        @(posedge clk);
        #1 rdy_i = 1'b1;
        @(negedge clk); chk("bp_out0", 32'(so), 32'h0002); chk("bp_v0", 32'(val_o), 32'(1));
        @(negedge clk); chk("bp_out1", 32'(so), 32'h0004); chk("bp_v1", 32'(val_o), 32'(1));
        @(negedge clk); chk("bp_out2", 32'(so), 32'h0006); chk("bp_v2", 32'(val_o), 32'(1));
      end
    join
    @(posedge clk);
    #1;

    // Mid-cycle reset with two transactions in flight.
    push(16'h0011, 16'h0022, 1'b0, 1'b0);
    push(16'h0100, 16'h0200, 1'b0, 1'b0);
    chk("rst_inflight", 32'(val_o), 32'(1));
    #2 rstn = 1'b0;
    #1;
    chk("mrst_val_o", 32'(val_o), 32'(0));
    chk("mrst_so",    32'(so),    32'(0));
    chk("mrst_rdy_o", 32'(rdy_o), 32'(1));
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(val_o), 32'(0));
    end
    @(posedge clk);
    #1;
    do_one("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Random traffic with gaps and random back-pressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          push(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!rnd_done && cyc < 8000) begin
          @(posedge clk);
          #1 rdy_i = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        rdy_i = 1'b1;
      end
    join
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
